// File: rtl/reset_button_conditioner.sv
// Button front end: 2-FF sync, debounce FSM, press/release/long pulses, stretched reset request.
// Press/release events appear DEBOUNCE_CYCLES+3 edges after the pin is first sampled; no backpressure.
module reset_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int STRETCH_CYCLES  = 1024,
  parameter int LONG_CYCLES     = 16777216,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter bit RST_ON_PRESS    = 1'b1
) (
  input  logic CLK,
  input  logic RESET,
  input  logic btn_raw,
  output logic rst_req,
  output logic btn_state,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam int SW = $clog2(STRETCH_CYCLES + 1);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_CYCLES - 2);
  localparam logic [SW-1:0] STR_MAX  = SW'(STRETCH_CYCLES - 1);

  typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

  logic          sync1_q, sync1_d, sync2_q, sync2_d, btn_s_q, btn_s_d;
  state_t        state_q, state_d;
  logic [DW-1:0] deb_q, deb_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [SW-1:0] str_q, str_d;
  logic          rst_q, rst_d;
  logic          btn_state_q, btn_state_d;
  logic          press_q, press_d, release_q, release_d, long_q, long_d;

  always_comb begin
    sync1_d     = btn_raw ^ ACTIVE_LOW;
    sync2_d     = sync1_q;
    // Registered copy of the synchroniser output puts FSM entry at edge 3 after first sample.
    btn_s_d     = sync2_q;
    state_d     = state_q;
    deb_d       = deb_q;
    hold_d      = hold_q;
    btn_state_d = btn_state_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;

    case (state_q)
      RELEASED: begin
        if (btn_s_q) begin
          state_d = PRESS_WAIT;
          deb_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s_q) begin
          state_d = RELEASED;
        end else if (deb_q == DEB_MAX) begin
          state_d     = PRESSED;
          btn_state_d = 1'b1;
          press_d     = 1'b1;
          hold_d      = '0;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      PRESSED, RELEASE_WAIT: begin
        // Hold time keeps running through release bounce; saturation makes long_pulse one-shot.
        if (hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;
        if (hold_q == HOLD_PRE) long_d = 1'b1;
        if (state_q == PRESSED) begin
          if (!btn_s_q) begin
            state_d = RELEASE_WAIT;
            deb_d   = '0;
          end
        end else if (btn_s_q) begin
          state_d = PRESSED;
        end else if (deb_q == DEB_MAX) begin
          state_d     = RELEASED;
          btn_state_d = 1'b0;
          release_d   = 1'b1;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
    endcase

    rst_d = rst_q;
    str_d = str_q;
    if (RST_ON_PRESS && press_q) begin
      str_d = '0;
      rst_d = 1'b1;
    end else if (rst_q && (str_q == STR_MAX)) begin
      rst_d = 1'b0;
    end else if (rst_q) begin
      str_d = str_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      btn_s_q     <= 1'b0;
      state_q     <= RELEASED;
      deb_q       <= '0;
      hold_q      <= '0;
      str_q       <= '0;
      rst_q       <= 1'b1;
      btn_state_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      btn_s_q     <= btn_s_d;
      state_q     <= state_d;
      deb_q       <= deb_d;
      hold_q      <= hold_d;
      str_q       <= str_d;
      rst_q       <= rst_d;
      btn_state_q <= btn_state_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
    end
  end

  assign rst_req       = rst_q;
  assign btn_state     = btn_state_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;

endmodule

// File: tb/tb_reset_button_conditioner.sv
// Directed stimulus pushes expected events (kind, edge number, button level) into a queue;
// a negedge monitor pops and compares every pulse and every rst_req edge the DUT produces.
module tb_reset_button_conditioner;

  logic CLK = 1'b0;
  logic RESET;
  logic btn_raw;
  logic rst_req, btn_state, press_pulse, release_pulse, long_pulse;

  reset_button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .STRETCH_CYCLES (8),
    .LONG_CYCLES    (20),
    .ACTIVE_LOW     (1'b1),
    .RST_ON_PRESS   (1'b1)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .btn_raw      (btn_raw),
    .rst_req      (rst_req),
    .btn_state    (btn_state),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse)
  );

  always #5 CLK = ~CLK;

  typedef enum int {EV_PRESS, EV_RELEASE, EV_LONG, EV_RST_RISE, EV_RST_FALL} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       edge_no;
    bit       chk_state;
    logic     state;
  } ev_t;

  ev_t  exp_q[$];
  int   edge_n = 0;
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  logic rst_prev = 1'b1;
  int   t0, r0, e0;

  always @(posedge CLK) edge_n <= edge_n + 1;

  task automatic push(input ev_kind_t k, input int e, input bit cs, input logic st);
    ev_t ev;
    ev.kind = k; ev.edge_no = e; ev.chk_state = cs; ev.state = st;
    exp_q.push_back(ev);
  endtask

  task automatic check(input string nm, input logic act, input logic exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b, expected %b (edge %0d)", nm, act, exp, edge_n);
  endtask

  task automatic match(input ev_kind_t k);
    int idx;
    idx = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].kind == k) begin
        idx = i;
        break;
      end
    end
    chk_cnt++;
    if (idx < 0) begin
      $display("FAIL %s: unexpected event at edge %0d, none expected", k.name(), edge_n);
    end else begin
      if (exp_q[idx].edge_no != edge_n)
        $display("FAIL %s: seen at edge %0d, expected edge %0d", k.name(), edge_n, exp_q[idx].edge_no);
      else if (exp_q[idx].chk_state && (btn_state !== exp_q[idx].state))
        $display("FAIL %s: btn_state %b at edge %0d, expected %b", k.name(), btn_state, edge_n, exp_q[idx].state);
      else
        pass_cnt++;
      exp_q.delete(idx);
    end
  endtask

  always @(negedge CLK) begin
    if (press_pulse   === 1'b1) match(EV_PRESS);
    if (release_pulse === 1'b1) match(EV_RELEASE);
    if (long_pulse    === 1'b1) match(EV_LONG);
    if (rst_req === 1'b1 && rst_prev === 1'b0) match(EV_RST_RISE);
    if (rst_req === 1'b0 && rst_prev === 1'b1) match(EV_RST_FALL);
    rst_prev = rst_req;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    @(negedge CLK);
    check({tag, " rst_req"},       rst_req,       1'b1);
    check({tag, " btn_state"},     btn_state,     1'b0);
    check({tag, " press_pulse"},   press_pulse,   1'b0);
    check({tag, " release_pulse"}, release_pulse, 1'b0);
    check({tag, " long_pulse"},    long_pulse,    1'b0);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET   = 1'b0;
    btn_raw = 1'b1;
    #1 RESET = 1'b1;

    // Power-on: stretch lasts 8 edges after RESET falls.
    repeat (3) @(posedge CLK);
    check_reset_vals("poweron");
    RESET = 1'b0;
    push(EV_RST_FALL, edge_n + 8, 1'b0, 1'b0);
    wait_cyc(12);

    // Clean press, released before the long-press threshold.
    btn_raw = 1'b0;
    t0 = edge_n + 1;
    push(EV_PRESS,    t0 + 7,  1'b1, 1'b1);
    push(EV_RST_RISE, t0 + 8,  1'b0, 1'b0);
    push(EV_RST_FALL, t0 + 16, 1'b0, 1'b0);
    wait_cyc(10);
    btn_raw = 1'b1;
    r0 = edge_n + 1;
    push(EV_RELEASE, r0 + 7, 1'b1, 1'b0);
    wait_cyc(15);

    // Bouncy press never held long enough.
    btn_raw = 1'b0; wait_cyc(3);
    btn_raw = 1'b1; wait_cyc(1);
    btn_raw = 1'b0; wait_cyc(2);
    btn_raw = 1'b1; wait_cyc(15);
    @(negedge CLK);
    check("bounce btn_state", btn_state, 1'b0);
    check("bounce rst_req",   rst_req,   1'b0);
    @(posedge CLK); #1;

    // Long press held 40 cycles.
    btn_raw = 1'b0;
    t0 = edge_n + 1;
    push(EV_PRESS,    t0 + 7,  1'b1, 1'b1);
    push(EV_RST_RISE, t0 + 8,  1'b0, 1'b0);
    push(EV_RST_FALL, t0 + 16, 1'b0, 1'b0);
    push(EV_LONG,     t0 + 26, 1'b1, 1'b1);
    wait_cyc(40);
    btn_raw = 1'b1;
    r0 = edge_n + 1;
    push(EV_RELEASE, r0 + 7, 1'b1, 1'b0);
    wait_cyc(15);

    // Press with a 2-cycle release bounce; hold time is not cleared, so long still fires.
    btn_raw = 1'b0;
    t0 = edge_n + 1;
    push(EV_PRESS,    t0 + 7,  1'b1, 1'b1);
    push(EV_RST_RISE, t0 + 8,  1'b0, 1'b0);
    push(EV_RST_FALL, t0 + 16, 1'b0, 1'b0);
    push(EV_LONG,     t0 + 26, 1'b1, 1'b1);
    wait_cyc(12);
    btn_raw = 1'b1; wait_cyc(2);
    btn_raw = 1'b0; wait_cyc(20);
    @(negedge CLK);
    check("relbounce btn_state", btn_state, 1'b1);
    @(posedge CLK); #1;

    // Reset while still held: rst_req rises immediately, then a fresh press after the stretch.
    RESET = 1'b1;
    push(EV_RST_RISE, edge_n, 1'b0, 1'b0);
    wait_cyc(2);
    check_reset_vals("midreset");
    RESET = 1'b0;
    e0 = edge_n;
    push(EV_RST_FALL, e0 + 8,  1'b0, 1'b0);
    push(EV_PRESS,    e0 + 8,  1'b1, 1'b1);
    push(EV_RST_RISE, e0 + 9,  1'b0, 1'b0);
    push(EV_RST_FALL, e0 + 17, 1'b0, 1'b0);
    wait_cyc(14);
    btn_raw = 1'b1;
    r0 = edge_n + 1;
    push(EV_RELEASE, r0 + 7, 1'b1, 1'b0);
    wait_cyc(30);

    chk_cnt++;
    if (exp_q.size() == 0) begin
      pass_cnt++;
    end else begin
      foreach (exp_q[i])
        $display("FAIL %s: missing, expected at edge %0d", exp_q[i].kind.name(), exp_q[i].edge_no);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
